// File: rtl/spi_debug_master_pkg.sv
// Shared definitions for the SPI debug-link initiator: word size, FSM state
// encoding and a helper for sizing down-counters.
package spi_debug_master_pkg;

  localparam int WORD_BITS = 16;
  localparam int BITCNT_W  = $clog2(WORD_BITS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FRAME    = 3'd1,
    ST_SETUP    = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_WAIT     = 3'd4,
    ST_IDLE_END = 3'd5
  } state_e;

  // Bits needed for a down-counter that starts at n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_debug_master_tick_gen.sv
// SPI half-period tick generator: a down-counter that pulses tick_o once
// every CLKDIV sys_clk cycles while enabled. restart_i reloads the count so
// the first tick lands exactly CLKDIV cycles after a state entry.
module spi_tick_gen
  import spi_debug_master_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = cnt_width(CLKDIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick fires at terminal count; it is not masked by restart so the tick
  // that causes a state change still takes effect.
  assign tick_o = en_i && (cnt_q == '0);

  // Next count: reload on restart or terminal count, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_debug_master.sv
// SPI initiator for the debug write link. Serialises 16-bit words LSB-first
// on a CS-framed bus; first word of a frame is the address. Framing pulses
// with CS high reset the slave's bit counter before each frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CS high, sclk low, ready for the first (address) word
// FRAME    | CS high, FRAME_PULSES sclk pulses to resync the slave
// SETUP    | CS low, MOSI holds bit 0, CS_SETUP cycles before shifting
// SHIFT    | 16 sclk pulses; MOSI moves on falls, MISO sampled on rises
// WAIT     | CS low, sclk low, waiting (any length) for the next word
// IDLE_END | CS low hold for one half-period before CS rises
module spi_debug_master
  import spi_debug_master_pkg::*;
#(
  parameter int CLKDIV       = 4,
  parameter int FRAME_PULSES = 2,
  parameter int CS_SETUP     = 4
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_last,
  output logic                 rx_valid,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 busy,
  output logic                 spi_clk_o,
  output logic                 spi_cs_o,
  output logic                 spi_data_o,
  input  logic                 spi_data_i
);

  localparam int FW = cnt_width(2 * FRAME_PULSES);
  localparam logic [FW-1:0] FRAME_RELOAD = FW'(2 * FRAME_PULSES - 1);
  localparam int SW = cnt_width(CS_SETUP);
  localparam logic [SW-1:0] SETUP_RELOAD = SW'(CS_SETUP - 1);
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WORD_BITS - 1);

  state_e                state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [WORD_BITS-1:0]  shift_q, shift_d;
  logic [WORD_BITS-1:0]  rxshift_q, rxshift_d;
  logic [WORD_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  last_q, last_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic [SW-1:0]         setup_cnt_q, setup_cnt_d;

  logic tick;
  logic tick_en;
  logic tick_restart;
  logic accept;

  assign tick_en  = (state_q != ST_IDLE) && (state_q != ST_WAIT);
  // Ready is a function of state only; held low while reset is asserted.
  assign tx_ready = ((state_q == ST_IDLE) || (state_q == ST_WAIT)) && !reset;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != ST_IDLE);

  assign spi_cs_o   = cs_q;
  assign spi_clk_o  = sclk_q;
  assign spi_data_o = mosi_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

  spi_tick_gen #(
    .CLKDIV (CLKDIV)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .en_i      (tick_en),
    .restart_i (tick_restart),
    .tick_o    (tick)
  );

  // Next-state and output-register logic for the framing/shift sequencer.
  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    shift_d      = shift_q;
    rxshift_d    = rxshift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    last_d       = last_q;
    bitcnt_d     = bitcnt_q;
    frame_cnt_d  = frame_cnt_q;
    setup_cnt_d  = setup_cnt_q;
    tick_restart = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (accept) begin
          shift_d      = tx_data;
          last_d       = tx_last;
          bitcnt_d     = '0;
          frame_cnt_d  = FRAME_RELOAD;
          tick_restart = 1'b1;
          state_d      = ST_FRAME;
        end
      end

      ST_FRAME: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (frame_cnt_q == '0) begin
            cs_d         = 1'b0;
            mosi_d       = shift_q[0];
            setup_cnt_d  = SETUP_RELOAD;
            tick_restart = 1'b1;
            state_d      = ST_SETUP;
          end else begin
            frame_cnt_d = frame_cnt_q - 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (setup_cnt_q == '0) begin
          tick_restart = 1'b1;
          state_d      = ST_SHIFT;
        end else begin
          setup_cnt_d = setup_cnt_q - 1'b1;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            rxshift_d = {spi_data_i, rxshift_q[WORD_BITS-1:1]};
          end else begin
            sclk_d   = 1'b0;
            shift_d  = shift_q >> 1;
            mosi_d   = shift_q[1];
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == LAST_BIT) begin
              rx_data_d  = rxshift_q;
              rx_valid_d = 1'b1;
              state_d    = last_q ? ST_IDLE_END : ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        if (accept) begin
          shift_d      = tx_data;
          last_d       = tx_last;
          mosi_d       = tx_data[0];
          bitcnt_d     = '0;
          tick_restart = 1'b1;
          state_d      = ST_SHIFT;
        end
      end

      ST_IDLE_END: begin
        if (tick) begin
          cs_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      shift_q     <= '0;
      rxshift_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      last_q      <= 1'b0;
      bitcnt_q    <= '0;
      frame_cnt_q <= '0;
      setup_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      shift_q     <= shift_d;
      rxshift_q   <= rxshift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      last_q      <= last_d;
      bitcnt_q    <= bitcnt_d;
      frame_cnt_q <= frame_cnt_d;
      setup_cnt_q <= setup_cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_debug_master.sv
// Bench for spi_debug_master: a behavioural debug-port slave decodes MOSI
// into address/write records, a MISO model returns a fixed word, and
// monitors count clock edges, MOSI changes while sclk is high and rx pulses.
module tb_spi_debug_master;

  localparam int CLKDIV = 2;
  localparam int FP     = 2;
  localparam int CSS    = 4;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic        tx_last = 1'b0;
  logic        tx_ready, rx_valid, busy;
  logic [15:0] rx_data;
  logic        spi_clk_o, spi_cs_o, spi_data_o, spi_data_i;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  spi_debug_master #(
    .CLKDIV       (CLKDIV),
    .FRAME_PULSES (FP),
    .CS_SETUP     (CSS)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .busy       (busy),
    .spi_clk_o  (spi_clk_o),
    .spi_cs_o   (spi_cs_o),
    .spi_data_o (spi_data_o),
    .spi_data_i (spi_data_i)
  );

  // Slave model: CS-high edges resync; first word of a frame is the address.
  logic [15:0] s_sr = 16'h0;
  logic [15:0] s_addr = 16'h0;
  int          s_cnt = 0;
  bit          s_aflag = 1'b0;
  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];
  int          rise_hi = 0;
  int          rise_lo = 0;
  time         t_r1 = 0;
  time         t_r16 = 0;

  always @(posedge spi_clk_o) begin
    if (spi_cs_o) begin
      rise_hi++;
      s_cnt   = 0;
      s_aflag = 1'b1;
    end else begin
      rise_lo++;
      s_sr = {spi_data_o, s_sr[15:1]};
      s_cnt++;
      if (s_cnt == 1) t_r1 = $time;
      if (s_cnt == 16) begin
        t_r16 = $time;
        s_cnt = 0;
        if (s_aflag) begin
          s_addr  = s_sr;
          s_aflag = 1'b0;
        end else begin
          wr_a.push_back(s_addr);
          wr_d.push_back(s_sr);
          s_addr = s_addr + 16'h1;
        end
      end
    end
  end

  // MISO model: bit index advances after each rising edge with CS low.
  logic [15:0] miso_word = 16'h0;
  logic [3:0]  miso_idx = 4'h0;
  assign spi_data_i = miso_word[miso_idx];

  always @(posedge spi_clk_o) begin
    if (spi_cs_o) miso_idx = 4'h0;
    else          miso_idx = miso_idx + 4'h1;
  end

  // MOSI must hold while sclk stays high between two sample points.
  logic prev_clk = 1'b0;
  logic prev_mosi = 1'b0;
  int   glitches = 0;
  always @(negedge sys_clk) begin
    if (!reset && prev_clk && spi_clk_o && (spi_data_o !== prev_mosi)) glitches++;
    prev_clk  = spi_clk_o;
    prev_mosi = spi_data_o;
  end

  int          rxv_cnt = 0;
  logic [15:0] rx_seen = 16'h0;
  always @(negedge sys_clk) begin
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_seen = rx_data;
    end
  end

  task automatic send_word(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_timeout tx_ready=%b expected=1", tx_ready);
    end
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; failures++;
      $display("FAIL idle_timeout busy=%b expected=0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (spi_cs_o !== 1'b1) begin failures++; $display("FAIL rst_cs got=%b exp=1", spi_cs_o); end
    checks++; if (spi_clk_o !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", spi_clk_o); end
    checks++; if (spi_data_o !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", spi_data_o); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 16'h0) begin failures++; $display("FAIL rst_rx_data got=%h exp=0000", rx_data); end
    reset = 1'b0;
    @(negedge sys_clk);
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL idle_tx_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_frame_writes();
    int n0;
    n0 = wr_a.size();
    send_word(16'h1234, 1'b0);
    send_word(16'hBEEF, 1'b0);
    send_word(16'h0001, 1'b1);
    wait_idle();
    checks++;
    if (wr_a.size() != n0 + 2) begin
      failures++; $display("FAIL frame_wr_count got=%0d exp=%0d", wr_a.size() - n0, 2);
    end else begin
      checks++; if (wr_a[n0] !== 16'h1234) begin failures++; $display("FAIL frame_waddr0 got=%h exp=1234", wr_a[n0]); end
      checks++; if (wr_d[n0] !== 16'hBEEF) begin failures++; $display("FAIL frame_wdata0 got=%h exp=beef", wr_d[n0]); end
      checks++; if (wr_a[n0+1] !== 16'h1235) begin failures++; $display("FAIL frame_waddr1 got=%h exp=1235", wr_a[n0+1]); end
      checks++; if (wr_d[n0+1] !== 16'h0001) begin failures++; $display("FAIL frame_wdata1 got=%h exp=0001", wr_d[n0+1]); end
    end
  endtask

  task automatic test_bit_timing();
    int hi0, lo0, g0;
    hi0 = rise_hi; lo0 = rise_lo; g0 = glitches;
    send_word(16'h0001, 1'b1);
    wait_idle();
    checks++; if (rise_hi - hi0 != FP) begin failures++; $display("FAIL bt_frame_pulses got=%0d exp=%0d", rise_hi - hi0, FP); end
    checks++; if (rise_lo - lo0 != 16) begin failures++; $display("FAIL bt_data_rises got=%0d exp=16", rise_lo - lo0); end
    checks++; if (s_addr !== 16'h0001) begin failures++; $display("FAIL bt_mosi_word got=%h exp=0001", s_addr); end
    checks++; if (t_r16 - t_r1 != 30 * CLKDIV * 10) begin failures++; $display("FAIL bt_word_time got=%0t exp=%0d", t_r16 - t_r1, 30 * CLKDIV * 10); end
    checks++; if (glitches != g0) begin failures++; $display("FAIL bt_mosi_stable got=%0d exp=0 changes with sclk high", glitches - g0); end
  endtask

  task automatic test_miso_capture();
    int r0;
    miso_word = 16'hA5C3;
    r0 = rxv_cnt;
    send_word(16'h0000, 1'b1);
    wait_idle();
    checks++; if (rxv_cnt - r0 != 1) begin failures++; $display("FAIL miso_rx_pulses got=%0d exp=1", rxv_cnt - r0); end
    checks++; if (rx_seen !== 16'hA5C3) begin failures++; $display("FAIL miso_rx_data got=%h exp=a5c3", rx_seen); end
    checks++; if (rx_data !== 16'hA5C3) begin failures++; $display("FAIL miso_rx_hold got=%h exp=a5c3", rx_data); end
  endtask

  task automatic test_stall();
    int n, bad, hi0, n0;
    n0 = wr_a.size();
    send_word(16'h0040, 1'b0);
    n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin @(negedge sys_clk); n++; end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (spi_cs_o !== 1'b0 || spi_clk_o !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) bad++;
      @(negedge sys_clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    hi0 = rise_hi;
    send_word(16'h7777, 1'b1);
    wait_idle();
    checks++; if (rise_hi != hi0) begin failures++; $display("FAIL stall_no_framing got=%0d exp=0", rise_hi - hi0); end
    checks++;
    if (wr_a.size() != n0 + 1) begin
      failures++; $display("FAIL stall_wr_count got=%0d exp=1", wr_a.size() - n0);
    end else begin
      checks++; if (wr_a[n0] !== 16'h0040) begin failures++; $display("FAIL stall_waddr got=%h exp=0040", wr_a[n0]); end
      checks++; if (wr_d[n0] !== 16'h7777) begin failures++; $display("FAIL stall_wdata got=%h exp=7777", wr_d[n0]); end
    end
  endtask

  task automatic test_reset_mid_word();
    int n, n0;
    send_word(16'h0033, 1'b0);
    n = 0;
    while (!(s_cnt == 7 && spi_cs_o === 1'b0) && n < 5000) begin @(negedge sys_clk); n++; end
    checks++; if (s_cnt != 7) begin failures++; $display("FAIL mid_reach_bit7 got=%0d exp=7", s_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (spi_cs_o !== 1'b1) begin failures++; $display("FAIL mid_cs got=%b exp=1", spi_cs_o); end
    checks++; if (spi_clk_o !== 1'b0) begin failures++; $display("FAIL mid_sclk got=%b exp=0", spi_clk_o); end
    checks++; if (spi_data_o !== 1'b0) begin failures++; $display("FAIL mid_mosi got=%b exp=0", spi_data_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL mid_tx_ready got=%b exp=0", tx_ready); end
    checks++; if (rx_data !== 16'h0) begin failures++; $display("FAIL mid_rx_data got=%h exp=0000", rx_data); end
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    n0 = wr_a.size();
    send_word(16'h0010, 1'b0);
    send_word(16'h5555, 1'b1);
    wait_idle();
    checks++;
    if (wr_a.size() != n0 + 1) begin
      failures++; $display("FAIL mid_wr_count got=%0d exp=1", wr_a.size() - n0);
    end else begin
      checks++; if (wr_a[n0] !== 16'h0010) begin failures++; $display("FAIL mid_waddr got=%h exp=0010", wr_a[n0]); end
      checks++; if (wr_d[n0] !== 16'h5555) begin failures++; $display("FAIL mid_wdata got=%h exp=5555", wr_d[n0]); end
    end
  endtask

  task automatic test_single_word();
    int n0;
    n0 = wr_a.size();
    send_word(16'h00FF, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sw_busy_high got=%b exp=1", busy); end
    wait_idle();
    checks++; if (spi_cs_o !== 1'b1) begin failures++; $display("FAIL sw_cs_at_idle got=%b exp=1", spi_cs_o); end
    checks++; if (s_addr !== 16'h00FF) begin failures++; $display("FAIL sw_addr got=%h exp=00ff", s_addr); end
    checks++; if (wr_a.size() != n0) begin failures++; $display("FAIL sw_no_write got=%0d exp=0", wr_a.size() - n0); end
  endtask

  initial begin
    test_reset();
    test_frame_writes();
    test_bit_timing();
    test_miso_capture();
    test_stall();
    test_reset_mid_word();
    test_single_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
